count_uart_tx: RTL

//  Downstream stage of the gated edge counter. On each gate strobe it captures the
//  8-bit count and converts it to three ASCII decimal digits plus CR LF, then sends
//  the 5-byte frame on a UART TX line (8N1).

---
 rtl/count_uart_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/count_uart_tx.sv
// Purpose : captures an 8-bit count on a start strobe and sends it as "DDD\r\n" (8N1 UART).
// Latency : tx falls 9 clk_in edges after the capture edge; busy high 8 + 50*CLKS_PER_BIT cycles.
// Backpr. : none; a start while busy is dropped and flagged by a 1-cycle overrun pulse.
//
// Ports:
//   clk_in   - system clock, rising edge
//   reset    - synchronous active-low reset
//   start    - 1-cycle strobe, captures data_in when idle
//   data_in  - unsigned count to report
//   tx       - registered UART line, idle high
//   busy     - high from the capture edge until the edge that ends the last stop bit
//   overrun  - 1-cycle pulse after a start that arrived while busy
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    conv_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    // {hundreds, tens, ones, binary}; after 8 steps the binary part is consumed.
    logic [19:0]   bcd_sh;
    logic          bit_end;
    logic          tx_nxt;
    logic [7:0]    cur_byte;

    // One double-dabble step: bias any digit >= 5 by 3, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != S_IDLE);

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            3'd0:    cur_byte = {4'h3, bcd_sh[19:16]};
            3'd1:    cur_byte = {4'h3, bcd_sh[15:12]};
            3'd2:    cur_byte = {4'h3, bcd_sh[11:8]};
            3'd3:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // tx is registered from tx_nxt, so the line lags the state by one cycle;
    // this is why the start bit appears 9 edges after capture while the FSM
    // reaches START after 8.
    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_CONV;
            end
            S_CONV: begin
                if (conv_cnt == 3'd7) state_nxt = S_START;
            end
            S_START: begin
                tx_nxt = 1'b0;
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                tx_nxt = cur_byte[bit_idx];
                if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_nxt = (byte_idx == 3'd4) ? S_IDLE : S_START;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            overrun  <= 1'b0;
            baud_cnt <= '0;
            conv_cnt <= 3'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            bcd_sh   <= 20'd0;
        end else begin
            state   <= state_nxt;
            tx      <= tx_nxt;
            overrun <= start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bcd_sh   <= {12'd0, data_in};
                        conv_cnt <= 3'd0;
                    end
                end
                S_CONV: begin
                    bcd_sh   <= dabble_step(bcd_sh);
                    conv_cnt <= conv_cnt + 3'd1;
                    baud_cnt <= '0;
                    bit_idx  <= 3'd0;
                    byte_idx <= 3'd0;
                end
                S_START, S_DATA, S_STOP: begin
                    // Reload exactly at the bit boundary so every bit is CLKS_PER_BIT long.
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    // bit_idx wraps 7 -> 0, ready for the next byte.
                    if (state == S_DATA && bit_end)
                        bit_idx <= bit_idx + 3'd1;
                    if (state == S_STOP && bit_end && byte_idx != 3'd4)
                        byte_idx <= byte_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
